// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer and its companion counter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width that can hold the values 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter with zero/one flags; saturates at zero.
module bit_down_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero,
  output logic         one
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
  assign one  = (cnt == W'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with READY/LOAD handshake and a DONE pulse
// after the last bit is consumed.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [N-1:0] D,
  input  logic         EN,
  output logic         READY,
  output logic         BUSY,
  output logic         SOUT,
  output logic         DONE
);

  localparam int unsigned CNT_W = cnt_width(N);

  state_t             state;
  logic   [N-1:0]     shreg;
  logic   [CNT_W-1:0] cnt;
  logic               cnt_zero;
  logic               cnt_one;
  logic               accept;
  logic               consume;

  assign accept  = (state == IDLE) && LOAD;
  assign consume = (state == SHIFT) && EN;

  bit_down_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (CLK),
    .rst  (RST),
    .load (accept),
    .value(CNT_W'(N)),
    .dec  (consume),
    .cnt  (cnt),
    .zero (cnt_zero),
    .one  (cnt_one)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      shreg <= '0;
      DONE  <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (LOAD) begin
            shreg <= D;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_zero) begin
            // Unreachable in normal operation; recovers if the counter is ever empty mid-word.
            state <= IDLE;
          end else if (EN) begin
            if (MSB_FIRST) shreg <= {shreg[N-2:0], 1'b0};
            else           shreg <= {1'b0, shreg[N-1:1]};
            if (cnt_one) begin
              state <= IDLE;
              DONE  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign READY = (state == IDLE) && !RST;
  assign BUSY  = (state == SHIFT);
  assign SOUT  = BUSY && (MSB_FIRST ? shreg[N-1] : shreg[0]);

endmodule
